// File: rtl/sipo_stream_buf_if.sv
// sipo_stream_buf_if: write-side and frame-side signals of the SIPO frame
// assembler, bundled so the bus master and the assembler share one port.
interface sipo_stream_buf_if #(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = $clog2(N_REG)
);
  logic                          clr;
  logic                          mode;
  logic                          load;
  logic [N_REG_BITS-1:0]         addr;
  logic [R_DATA_WIDTH-1:0]       din;
  logic                          in_ready;
  logic [R_DATA_WIDTH*N_REG-1:0] dout;
  logic                          dout_valid;
  logic                          dout_ack;
  logic [N_REG_BITS:0]           wr_cnt;
  logic                          err_ovr;
  logic                          err_addr;

  // Producer/consumer side: drives words, flush and frame acknowledge.
  modport master (
    output clr, mode, load, addr, din, dout_ack,
    input  in_ready, dout, dout_valid, wr_cnt, err_ovr, err_addr
  );

  // Assembler side.
  modport slave (
    input  clr, mode, load, addr, din, dout_ack,
    output in_ready, dout, dout_valid, wr_cnt, err_ovr, err_addr
  );
endinterface

// File: rtl/sipo_stream_buf.sv
// sipo_stream_buf: collects N_REG words into one wide frame with auto-increment
// or addressed fill, completion tracking, valid/ack backpressure and sticky
// error flags. Optional build macro SIPO_STREAM_DBUF_EN adds a separate fill
// register so a new frame can be collected while the previous one is held.
module sipo_stream_buf #(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = $clog2(N_REG)
) (
  input  logic             clk,
  input  logic             rst,
  sipo_stream_buf_if.slave bus
);
  localparam int                   CW       = N_REG_BITS + 1;
  localparam logic [CW-1:0]        CNT_FULL = CW'(N_REG);
  localparam logic [N_REG_BITS-1:0] PTR_LAST = N_REG_BITS'(N_REG - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
  typedef logic [N_REG-1:0][R_DATA_WIDTH-1:0] frame_t;

  state_t                state_q, state_d;
  logic [N_REG_BITS-1:0] ptr_q, ptr_d;
  logic [N_REG-1:0]      mask_q, mask_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  mode_q, mode_d;
  frame_t                dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  err_ovr_q, err_ovr_d;
  logic                  err_addr_q, err_addr_d;
`ifdef SIPO_STREAM_DBUF_EN
  frame_t                fill_q, fill_d;
`endif

  logic                          in_ready;
  logic                          accept;
  logic                          frame_mode;
  logic                          addr_bad;
  logic [N_REG_BITS-1:0]         wr_idx;
  logic [(1<<N_REG_BITS)-1:0]    mask_ext;
  logic [CW-1:0]                 cnt_after;

  // Decode the incoming word: effective frame mode, target index, new count.
  always_comb begin
    in_ready   = (state_q == FILL);
    accept     = bus.load & in_ready;
    // Mode is only sampled while the frame is still empty.
    frame_mode = (wr_cnt_q == '0) ? bus.mode : mode_q;
    addr_bad   = frame_mode & ({1'b0, bus.addr} >= CNT_FULL);
    wr_idx     = frame_mode ? bus.addr : ptr_q;
    mask_ext   = '0;
    mask_ext[N_REG-1:0] = mask_q;
    // Addressed rewrites of an already-filled slot do not count again.
    if (frame_mode)
      cnt_after = wr_cnt_q + {{(CW-1){1'b0}}, ~mask_ext[wr_idx]};
    else
      cnt_after = wr_cnt_q + CW'(1);
  end

  // Next-state logic for fill tracking, frame hand-off and error flags.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mask_d       = mask_q;
    wr_cnt_d     = wr_cnt_q;
    mode_d       = mode_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_ovr_d    = err_ovr_q;
    err_addr_d   = err_addr_q;
`ifdef SIPO_STREAM_DBUF_EN
    fill_d       = fill_q;
`endif
    if (bus.clr) begin
      // Flush the frame in progress; the presented frame stays put.
      state_d    = FILL;
      ptr_d      = '0;
      mask_d     = '0;
      wr_cnt_d   = '0;
      mode_d     = 1'b0;
      err_ovr_d  = 1'b0;
      err_addr_d = 1'b0;
    end else begin
      if (bus.load && !in_ready)
        err_ovr_d = 1'b1;
      if (accept) begin
        mode_d = frame_mode;
        if (addr_bad) begin
          err_addr_d = 1'b1;
        end else begin
`ifdef SIPO_STREAM_DBUF_EN
          fill_d[wr_idx] = bus.din;
`else
          dout_d[wr_idx] = bus.din;
`endif
          if (frame_mode)
            mask_d[wr_idx] = 1'b1;
          else if (ptr_q != PTR_LAST)
            ptr_d = ptr_q + N_REG_BITS'(1);
          wr_cnt_d = cnt_after;
          if (cnt_after == CNT_FULL) begin
            state_d = FULL;
`ifndef SIPO_STREAM_DBUF_EN
            dout_valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef SIPO_STREAM_DBUF_EN
      // Move a completed fill into the output once the output slot is free.
      if (state_q == FULL && (!dout_valid_q || bus.dout_ack)) begin
        dout_d       = fill_q;
        dout_valid_d = 1'b1;
        state_d      = FILL;
        ptr_d        = '0;
        mask_d       = '0;
        wr_cnt_d     = '0;
      end else if (bus.dout_ack) begin
        dout_valid_d = 1'b0;
      end
`else
      // Consumer took the frame: reopen for the next one.
      if (state_q == FULL && bus.dout_ack) begin
        state_d      = FILL;
        ptr_d        = '0;
        mask_d       = '0;
        wr_cnt_d     = '0;
        dout_valid_d = 1'b0;
      end
`endif
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      ptr_q        <= '0;
      mask_q       <= '0;
      wr_cnt_q     <= '0;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_ovr_q    <= 1'b0;
      err_addr_q   <= 1'b0;
`ifdef SIPO_STREAM_DBUF_EN
      fill_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      wr_cnt_q     <= wr_cnt_d;
      mode_q       <= mode_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_ovr_q    <= err_ovr_d;
      err_addr_q   <= err_addr_d;
`ifdef SIPO_STREAM_DBUF_EN
      fill_q       <= fill_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.wr_cnt     = wr_cnt_q;
  assign bus.err_ovr    = err_ovr_q;
  assign bus.err_addr   = err_addr_q;
endmodule

// File: tb/tb_sipo_stream_buf.sv
// tb_sipo_stream_buf: directed frame scenarios plus random traffic, checked
// every cycle against a frame-level model (words written per frame as a set).
module tb_sipo_stream_buf;
  localparam int W  = 32;
  localparam int N  = 6;
  localparam int NB = $clog2(N);
  localparam int CW = NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sipo_stream_buf_if #(.R_DATA_WIDTH(W), .N_REG(N)) bus ();
  sipo_stream_buf #(.R_DATA_WIDTH(W), .N_REG(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: which slots of the current frame hold data, where data lives,
  // whether a complete frame is waiting, and the presented frame.
  logic [W-1:0] m_dout [N];
`ifdef SIPO_STREAM_DBUF_EN
  logic [W-1:0] m_fill [N];
`endif
  bit m_wr [N];
  bit m_full, m_valid, m_eovr, m_eaddr, m_mode;
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic int written_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_wr[i]);
    return c;
  endfunction

  task automatic model_update();
    bit was_full, was_valid, fm;
    int a, idx;
    was_full  = m_full;
    was_valid = m_valid;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_dout[i] = '0;
        m_wr[i]   = 1'b0;
      end
      m_full = 0; m_valid = 0; m_eovr = 0; m_eaddr = 0; m_mode = 0;
      return;
    end
    if (bus.clr) begin
      for (int i = 0; i < N; i++) m_wr[i] = 1'b0;
      m_full = 0; m_eovr = 0; m_eaddr = 0;
      return;
    end
    if (bus.load && was_full) m_eovr = 1;
    if (bus.load && !was_full) begin
      fm = (written_cnt() == 0) ? bus.mode : m_mode;
      m_mode = fm;
      a = int'(bus.addr);
      if (fm && a >= N) begin
        m_eaddr = 1;
      end else begin
        // Auto fill is always a prefix, so the next slot equals the count.
        idx = fm ? a : written_cnt();
`ifdef SIPO_STREAM_DBUF_EN
        m_fill[idx] = bus.din;
`else
        m_dout[idx] = bus.din;
`endif
        m_wr[idx] = 1'b1;
        if (written_cnt() == N) begin
          m_full = 1;
`ifndef SIPO_STREAM_DBUF_EN
          m_valid = 1;
`endif
        end
      end
    end
`ifdef SIPO_STREAM_DBUF_EN
    if (was_full && (!was_valid || bus.dout_ack)) begin
      for (int i = 0; i < N; i++) begin
        m_dout[i] = m_fill[i];
        m_wr[i]   = 1'b0;
      end
      m_valid = 1; m_full = 0;
    end else if (bus.dout_ack) begin
      m_valid = 0;
    end
`else
    if (was_full && bus.dout_ack) begin
      for (int i = 0; i < N; i++) m_wr[i] = 1'b0;
      m_full = 0; m_valid = 0;
    end
`endif
  endtask

  task automatic check_outputs();
    logic [W*N-1:0] e_dout;
    logic [CW-1:0]  e_cnt;
    bit             e_rdy;
    for (int i = 0; i < N; i++) e_dout[i*W +: W] = m_dout[i];
    e_cnt = CW'(written_cnt());
    e_rdy = ~m_full;
    n_vec++;
    if (bus.in_ready !== e_rdy || bus.dout !== e_dout || bus.dout_valid !== m_valid ||
        bus.wr_cnt !== e_cnt || bus.err_ovr !== m_eovr || bus.err_addr !== m_eaddr) begin
      n_bad++;
      $display("FAIL cycle %0d outputs: got rdy=%b vld=%b cnt=%0d eo=%b ea=%b dout=%h, required rdy=%b vld=%b cnt=%0d eo=%b ea=%b dout=%h",
               cyc, bus.in_ready, bus.dout_valid, bus.wr_cnt, bus.err_ovr, bus.err_addr, bus.dout,
               e_rdy, m_valid, e_cnt, m_eovr, m_eaddr, e_dout);
    end
  endtask

  task automatic lit(string name, logic [W*N-1:0] got, logic [W*N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, compare mid-cycle.
  task automatic step(bit r, bit c, bit m, bit ld, int a, logic [W-1:0] d, bit ack);
    rst = r; bus.clr = c; bus.mode = m; bus.load = ld;
    bus.addr = NB'(a); bus.din = d; bus.dout_ack = ack;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, 0);
  endtask

  logic [W*N-1:0] exp_frame;
  int t2_addr [7] = '{5, 3, 3, 0, 1, 2, 4};

  initial begin
    bus.clr = 0; bus.mode = 0; bus.load = 0; bus.addr = '0; bus.din = '0; bus.dout_ack = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    lit("reset dout", bus.dout, '0);
    lit("reset flags", {bus.in_ready, bus.dout_valid, bus.wr_cnt, bus.err_ovr, bus.err_addr},
        {1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b0});

    // T1: auto fill with 1..N.
    $display("T1 auto fill");
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0, W'(i + 1), 0);
    idle();
    for (int i = 0; i < N; i++) exp_frame[i*W +: W] = W'(i + 1);
    lit("t1 dout", bus.dout, exp_frame);
    lit("t1 valid", bus.dout_valid, 1);
`ifndef SIPO_STREAM_DBUF_EN
    lit("t1 in_ready", bus.in_ready, 0);
    lit("t1 wr_cnt", bus.wr_cnt, N);
`endif
    step(0, 0, 0, 0, 0, '0, 1);
    lit("t1 after ack", {bus.dout_valid, bus.in_ready, bus.wr_cnt}, {1'b0, 1'b1, {CW{1'b0}}});

    // T2: addressed fill with an overwrite of slot 3.
    $display("T2 addressed fill");
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 1, 1, t2_addr[k], (k == 2) ? 32'hAA : W'(t2_addr[k] * 32'h11), 0);
      if (k == 5) begin
        lit("t2 valid before last", bus.dout_valid, 0);
        lit("t2 wr_cnt before last", bus.wr_cnt, 5);
      end
    end
    idle();
    lit("t2 valid", bus.dout_valid, 1);
    lit("t2 word3", bus.dout[3*W +: W], 32'hAA);
    lit("t2 word5", bus.dout[5*W +: W], 32'h55);
    step(0, 0, 0, 0, 0, '0, 1);

    // T3: bad address, overrun while full, ack together with load.
    $display("T3 error flags");
    step(0, 0, 1, 1, 6, 32'h1234, 0);
    lit("t3 err_addr", bus.err_addr, 1);
    lit("t3 wr_cnt after bad addr", bus.wr_cnt, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0, W'(32'hA0 + i), 0);
    step(0, 0, 0, 1, 0, 32'hDEAD, 0);
    for (int i = 0; i < N; i++) exp_frame[i*W +: W] = W'(32'hA0 + i);
    lit("t3 err_ovr", bus.err_ovr, 1);
    lit("t3 dout kept", bus.dout, exp_frame);
    step(0, 1, 0, 0, 0, '0, 0);
    lit("t3 clr flags", {bus.err_ovr, bus.err_addr, bus.dout_valid}, 3'b001);
    lit("t3 clr keeps dout", bus.dout, exp_frame);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0, W'(32'hB0 + i), 0);
    step(0, 0, 0, 1, 0, 32'hBEEF, 1);
    lit("t3 ack+load", {bus.err_ovr, bus.in_ready, bus.wr_cnt}, {1'b1, 1'b1, {CW{1'b0}}});

    // T4: clr and rst in the middle of a frame.
    $display("T4 mid-frame flush");
    step(0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, W'(32'hC0 + i), 0);
    step(0, 1, 0, 0, 0, '0, 0);
    lit("t4 clr wr_cnt", bus.wr_cnt, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, W'(32'hD0 + i), 0);
    step(1, 0, 0, 0, 0, '0, 0);
    lit("t4 rst dout", bus.dout, '0);
    lit("t4 rst flags", {bus.dout_valid, bus.wr_cnt, bus.err_ovr, bus.err_addr}, '0);

    // Random traffic: mixed modes, stray acks, flushes, bad addresses.
    $display("random phase");
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
           int'($urandom_range(0, (1 << NB) - 1)), W'($urandom),
           $urandom_range(0, 9) < 3);
      if (bus.dout_valid && bus.dout_ack)
        $display("cycle %0d frame presented: %h", cyc, bus.dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
